// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS BCD hh:mm alarms with per-channel enable, ring timeout and snooze.
// Define ALARM_BANK_SNOOZE_EN to build the SNOOZE state; otherwise snooze acts as stop.
module alarm_bank #(
   parameter int NUM_ALARMS = 4,
   parameter int CH_W       = 2,
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  mode_alarm,
   input  logic [CH_W-1:0]       ch_sel,
   input  logic                  hour_set,
   input  logic                  min_set,
   input  logic                  en_toggle,
   input  logic                  stop,
   input  logic                  snooze,
   input  logic                  sec_tick,
   input  logic [23:0]           cur_time,
   output logic [31:0]           disp_alarm,
   output logic [NUM_ALARMS-1:0] alarm_en,
   output logic                  ringing,
   output logic                  snoozing,
   output logic [CH_W-1:0]       ring_ch
);

`ifdef ALARM_BANK_SNOOZE_EN
   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
   logic [9:0] snz_cnt_q, snz_cnt_d;
   logic       snoozing_q;
`else
   typedef enum logic [0:0] {IDLE, RINGING} state_t;
`endif

   state_t                  state_q, state_d;
   logic [7:0]              hh_q [NUM_ALARMS];
   logic [7:0]              hh_d [NUM_ALARMS];
   logic [7:0]              mm_q [NUM_ALARMS];
   logic [7:0]              mm_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0]   en_q, en_d;
   logic [7:0]              ring_cnt_q, ring_cnt_d;
   logic [CH_W-1:0]         ring_ch_q, ring_ch_d;
   logic                    ringing_q;
   logic                    ch_ok, edit_ok, hit, kill;
   logic [CH_W-1:0]         hit_ch;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      return (v == max) ? 8'h00 :
             (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
   endfunction

   assign ch_ok   = int'(ch_sel) < NUM_ALARMS;
   assign edit_ok = mode_alarm && ch_ok;

   always_comb begin
      hh_d = hh_q;
      mm_d = mm_q;
      en_d = en_q;
      if (edit_ok) begin
         if (hour_set)  hh_d[ch_sel] = bcd_inc(hh_q[ch_sel], 8'h23);
         if (min_set)   mm_d[ch_sel] = bcd_inc(mm_q[ch_sel], 8'h59);
         if (en_toggle) en_d[ch_sel] = ~en_q[ch_sel];
      end
   end

   // Scan downward so the lowest matching channel is the one left standing.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (en_q[i] && sec_tick && cur_time[7:0] == 8'h00 && cur_time[23:8] == {hh_q[i], mm_q[i]}) begin
            hit    = 1'b1;
            hit_ch = CH_W'(i);
         end
      end
   end

   // Clearing the active channel's enable silences it just like stop.
`ifdef ALARM_BANK_SNOOZE_EN
   assign kill = stop || (edit_ok && en_toggle && ch_sel == ring_ch_q && en_q[ring_ch_q]);
`else
   assign kill = stop || snooze || (edit_ok && en_toggle && ch_sel == ring_ch_q && en_q[ring_ch_q]);
`endif

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      ring_ch_d  = ring_ch_q;
`ifdef ALARM_BANK_SNOOZE_EN
      snz_cnt_d  = snz_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (hit) begin
               state_d    = RINGING;
               ring_ch_d  = hit_ch;
               ring_cnt_d = '0;
            end
         end
         RINGING: begin
            if (kill) state_d = IDLE;
`ifdef ALARM_BANK_SNOOZE_EN
            else if (snooze) begin
               state_d   = SNOOZE;
               snz_cnt_d = '0;
            end
`endif
            else if (sec_tick) begin
               if (ring_cnt_q == 8'(RING_SECS - 1)) state_d = IDLE;
               else ring_cnt_d = ring_cnt_q + 8'd1;
            end
         end
`ifdef ALARM_BANK_SNOOZE_EN
         SNOOZE: begin
            if (kill) state_d = IDLE;
            else if (sec_tick) begin
               if (snz_cnt_q == 10'(SNOOZE_MIN * 60 - 1)) begin
                  state_d    = RINGING;
                  ring_cnt_d = '0;
               end else snz_cnt_d = snz_cnt_q + 10'd1;
            end
         end
         default: state_d = IDLE;
`endif
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            hh_q[i] <= 8'h00;
            mm_q[i] <= 8'h00;
         end
         en_q       <= '0;
         state_q    <= IDLE;
         ring_cnt_q <= '0;
         ring_ch_q  <= '0;
         ringing_q  <= 1'b0;
      end else begin
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         en_q       <= en_d;
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         ring_ch_q  <= ring_ch_d;
         ringing_q  <= state_d == RINGING;
      end
   end

`ifdef ALARM_BANK_SNOOZE_EN
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         snz_cnt_q  <= '0;
         snoozing_q <= 1'b0;
      end else begin
         snz_cnt_q  <= snz_cnt_d;
         snoozing_q <= state_d == SNOOZE;
      end
   end
   assign snoozing = snoozing_q;
`else
   assign snoozing = 1'b0;
`endif

   assign disp_alarm = {ch_ok ? hh_q[ch_sel] : 8'h00, 4'ha, ch_ok ? mm_q[ch_sel] : 8'h00, 4'ha, 8'h00};
   assign alarm_en   = en_q;
   assign ringing    = ringing_q;
   assign ring_ch    = ring_ch_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_alarm_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_alarm = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic        hour_set = 1'b0, min_set = 1'b0, en_toggle = 1'b0, stop = 1'b0, snooze = 1'b0, sec_tick = 1'b0;
  logic [23:0] cur_time = '0;
  logic [31:0] disp_alarm;
  logic [3:0]  alarm_en;
  logic        ringing, snoozing;
  logic [1:0]  ring_ch;
  logic        done = 1'b0;

  alarm_bank dut (
    .sys_clk(clk), .rst_n(rst_n), .mode_alarm(mode_alarm), .ch_sel(ch_sel),
    .hour_set(hour_set), .min_set(min_set), .en_toggle(en_toggle), .stop(stop),
    .snooze(snooze), .sec_tick(sec_tick), .cur_time(cur_time), .disp_alarm(disp_alarm),
    .alarm_en(alarm_en), .ringing(ringing), .snoozing(snoozing), .ring_ch(ring_ch)
  );

  always #5 clk = ~clk;

  localparam int DISP = 0, EN = 1, RING = 2, SNZ = 3, CH = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] got;
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      got = cur.sel == DISP ? disp_alarm :
            cur.sel == EN   ? {28'd0, alarm_en} :
            cur.sel == RING ? {31'd0, ringing} :
            cur.sel == SNZ  ? {31'd0, snoozing} : {30'd0, ring_ch};
      total++;
      if (got !== cur.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", cur.name, got, cur.exp);
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: stimulus did not finish");
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int s, input logic [31:0] v);
    q.push_back('{n, s, v});
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin min_set = 1'b1; tick(); min_set = 1'b0; end
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin hour_set = 1'b1; tick(); hour_set = 1'b0; end
  endtask

  task automatic toggle(input logic [1:0] c);
    ch_sel = c; en_toggle = 1'b1; tick(); en_toggle = 1'b0;
  endtask

  task automatic sec(input logic [23:0] t);
    cur_time = t; sec_tick = 1'b1; tick(); sec_tick = 1'b0;
  endtask

  function automatic logic [7:0] bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    tick(); tick();
    if (disp_alarm !== 32'h00A00A00 || alarm_en !== 4'h0 || ringing !== 1'b0 || snoozing !== 1'b0 || ring_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_direct: disp=%h en=%h ring=%b snz=%b ch=%h", disp_alarm, alarm_en, ringing, snoozing, ring_ch);
    end
    chk("rst_disp", DISP, 32'h00A00A00);
    chk("rst_en", EN, 32'h0);
    chk("rst_ring", RING, 32'h0);
    chk("rst_snz", SNZ, 32'h0);
    chk("rst_ch", CH, 32'h0);
    tick();
    rst_n = 1'b1;
    mode_alarm = 1'b1;
    ch_sel = 2'd1;
    tick();
    pulse_min(24);
    pulse_hour(7);
    chk("ch1_0724", DISP, 32'h07A24A00);
    tick();
    ch_sel = 2'd0;
    chk("ch0_untouched", DISP, 32'h00A00A00);
    tick();
    ch_sel = 2'd2;
    pulse_min(59);
    pulse_hour(23);
    chk("ch2_2359", DISP, 32'h23A59A00);
    tick();
    hour_set = 1'b1; min_set = 1'b1; tick(); hour_set = 1'b0; min_set = 1'b0;
    chk("ch2_dual_wrap", DISP, 32'h00A00A00);
    tick();
    ch_sel = 2'd3;
    pulse_min(24);
    pulse_hour(7);
    toggle(2'd1);
    toggle(2'd3);
    chk("en_1010", EN, 32'hA);
    chk("ch3_0724", DISP, 32'h07A24A00);
    tick();
    mode_alarm = 1'b0;
    min_set = 1'b1; en_toggle = 1'b1; tick(); min_set = 1'b0; en_toggle = 1'b0;
    chk("mode0_no_edit", DISP, 32'h07A24A00);
    chk("mode0_no_toggle", EN, 32'hA);
    tick();
    mode_alarm = 1'b1;
    sec(24'h072300);
    chk("no_match_0723", RING, 32'h0);
    cur_time = 24'h072400; tick();
    chk("no_tick_no_ring", RING, 32'h0);
    stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
    chk("idle_stop_noop", RING, 32'h0);
    sec(24'h072400);
    chk("ring_on", RING, 32'h1);
    chk("ring_low_ch", CH, 32'h1);
    chk("ring_not_snz", SNZ, 32'h0);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_off", RING, 32'h0);
    tick();
    sec(24'h072400);
    for (int s = 1; s < 60; s++) sec({16'h0724, bcd(s)});
    chk("ring_59_ticks", RING, 32'h1);
    tick();
    sec(24'h072500);
    chk("timeout_off", RING, 32'h0);
    tick();
`ifdef ALARM_BANK_SNOOZE_EN
    sec(24'h072400);
    snooze = 1'b1; tick(); snooze = 1'b0;
    chk("snz_on", SNZ, 32'h1);
    chk("snz_not_ring", RING, 32'h0);
    tick();
    repeat (299) sec(24'h080001);
    chk("snz_299", SNZ, 32'h1);
    tick();
    sec(24'h080001);
    chk("resnz_ring", RING, 32'h1);
    chk("resnz_snz_off", SNZ, 32'h0);
    chk("resnz_ch", CH, 32'h1);
    tick();
    toggle(2'd1);
    chk("disable_off", RING, 32'h0);
    chk("disable_en", EN, 32'h8);
    tick();
`else
    sec(24'h072400);
    snooze = 1'b1; tick(); snooze = 1'b0;
    chk("snz_as_stop", RING, 32'h0);
    chk("snz_tied0", SNZ, 32'h0);
    tick();
    sec(24'h072400);
    toggle(2'd1);
    chk("disable_off", RING, 32'h0);
    chk("disable_en", EN, 32'h8);
    tick();
`endif
    sec(24'h072400);
    chk("ring_ch3", CH, 32'h3);
    chk("ring_ch3_on", RING, 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ring", RING, 32'h0);
    chk("midrst_ch", CH, 32'h0);
    chk("midrst_en", EN, 32'h0);
    chk("midrst_disp", DISP, 32'h00A00A00);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    done = 1'b1;
    if (bad != 0 || total == 0) $display("FAIL summary: total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-channel alarm unit for the digital clock; successor to the single-alarm setter.
- Holds NUM_ALARMS independent BCD hh:mm alarm times, each with its own enable bit.
- Compares every enabled channel against the running clock time and drives a ringing FSM with timeout and snooze.
- Sits between the time-keeping counter (cur_time, sec_tick) and the display mux / buzzer driver.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_ALARMS.
- RING_SECS, 60, seconds the alarm rings before auto-stop (1..255).
- SNOOZE_MIN, 5, snooze length in minutes (1..15).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode_alarm  in  1  1 = alarm-edit mode; set/toggle inputs are ignored when 0.
- ch_sel  in  CH_W  channel being edited and displayed.
- hour_set  in  1  single-cycle debounced pulse; increments the hour of ch_sel.
- min_set  in  1  single-cycle pulse; increments the minute of ch_sel.
- en_toggle  in  1  single-cycle pulse; toggles the enable bit of ch_sel.
- stop  in  1  single-cycle pulse; silences the alarm.
- snooze  in  1  single-cycle pulse; snoozes a ringing alarm.
- sec_tick  in  1  single-cycle pulse, once per second, aligned with cur_time update.
- cur_time  in  24  BCD {hh,mm,ss} of the running clock.
- disp_alarm  out  32  {hh_sel,4'ha,mm_sel,4'ha,8'h00}.
- alarm_en  out  NUM_ALARMS  per-channel enable bits.
- ringing  out  1  buzzer request.
- snoozing  out  1  high while in the SNOOZE state.
- ring_ch  out  CH_W  channel that triggered the current ring or snooze.

Behaviour:
- Reset: all times 00:00, alarm_en=0, FSM IDLE, ringing=0, snoozing=0, ring_ch=0, counters=0. disp_alarm follows channel 0 with time 00:00.
- Edit path (mode_alarm=1 only); the register updates at the next sys_clk edge:
  - min_set: BCD 00..59; wraps 59->00; no carry into hours.
  - hour_set: BCD 00..23; wraps 23->00.
  - en_toggle: flips alarm_en[ch_sel].
  - If hour_set and min_set arrive in the same cycle, both apply.
  - ch_sel >= NUM_ALARMS: edits are ignored and disp_alarm shows 00:00.
- disp_alarm is combinational from ch_sel and the stored times.
- Match: on a cycle with sec_tick=1, cur_time[7:0]==8'h00 and cur_time[23:8]=={hh[i],mm[i]} and alarm_en[i]=1.
  - If several channels match, the lowest index wins.
  - Matches are evaluated only in IDLE.
- FSM IDLE:
  - On a match -> RINGING next cycle; ring_ch=i; ring second counter=0.
- FSM RINGING (ringing=1):
  - stop -> IDLE.
  - snooze, without stop -> SNOOZE; snooze second counter=0.
  - Each sec_tick increments the ring counter; on reaching RING_SECS -> IDLE (auto-stop).
  - Priority: stop > snooze > timeout.
- FSM SNOOZE (snoozing=1, ringing=0):
  - stop -> IDLE.
  - Each sec_tick increments the counter; on reaching SNOOZE_MIN*60 -> RINGING with the ring counter cleared; the number of snoozes is unbounded.
- Disable while active: an en_toggle that clears alarm_en[ring_ch] in RINGING or SNOOZE forces IDLE next cycle.
- Time edits on the active channel do not affect the current ring or snooze.
- Outputs ringing and snoozing are registered and mutually exclusive.
- stop or snooze pulses in IDLE have no effect.
- Asserting rst_n low mid-ring returns immediately to the reset state.

Optional Feature:
- Macro: ALARM_BANK_SNOOZE_EN.
- Defined: snooze behaves as described above.
- Undefined: the SNOOZE state is not built; snoozing is tied 0; the snooze input is treated exactly like stop.

Test Plan:
- Reset, mode_alarm=1, ch_sel=1, 24 min_set pulses then 7 hour_set pulses -> disp_alarm=32'h07A24A00, channel 0 still 00:00.
- ch_sel=2 at 23:59; one hour_set and one min_set in the same cycle -> 00:00.
- ch1=07:24 enabled, ch3=07:24 enabled, cur_time=07:24:00 with sec_tick -> ringing=1 next cycle, ring_ch=1; stop -> ringing=0.
- Ring with RING_SECS=60 and no input -> ringing drops after the 60th sec_tick; no retrigger at 07:24:01.
- Ringing, snooze -> snoozing=1 for 300 sec_ticks, then ringing=1 again with the same ring_ch; en_toggle on that channel -> IDLE.
- ALARM_BANK_SNOOZE_EN undefined: snooze while ringing -> IDLE, snoozing stays 0; rst_n asserted mid-ring -> all outputs at reset values.
